// File: rtl/dshot_pkg.sv
// ============================================================================
// Module : dshot_pkg
// Brief  : DShot frame constants, FSM state type and checksum helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dshot_pkg;

    localparam int DSHOT_CMD_MAX      = 48;
    localparam int DSHOT_THROTTLE_MAX = 1999;
    localparam int DSHOT_FRAME_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } dshotState_t;

    function automatic logic [3:0] dshot_crc(input logic [11:0] d);
        logic [11:0] x;
        x = d ^ (d >> 4) ^ (d >> 8);
        return x[3:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dshot_frame_encoder.sv
// ============================================================================
// Module : dshot_frame_encoder
// Brief  : Combinational request-to-frame encoder {value, telem, crc}.
//          DSHOT_BIDIR_EN selects the inverted checksum.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dshot_frame_encoder
    import dshot_pkg::*;
(
    input  logic                     i_isCommand,
    input  logic [10:0]              i_value,
    input  logic                     i_telemetry,
    output logic [DSHOT_FRAME_W-1:0] o_frame,
    output logic                     o_cmdErr
);

    logic [10:0] w_code;
    logic [11:0] w_data;
    logic [3:0]  w_crc;

    // Throttle saturates at 1999 and is offset past the command space.
    always_comb begin
        w_code = i_value;
        if (!i_isCommand) begin
            if (i_value > 11'(DSHOT_THROTTLE_MAX))
                w_code = 11'(DSHOT_THROTTLE_MAX + DSHOT_CMD_MAX);
            else
                w_code = i_value + 11'(DSHOT_CMD_MAX);
        end
    end

    assign w_data = {w_code, i_telemetry};

`ifdef DSHOT_BIDIR_EN
    assign w_crc = ~dshot_crc(w_data);
`else
    assign w_crc = dshot_crc(w_data);
`endif

    assign o_frame  = {w_data, w_crc};
    assign o_cmdErr = i_isCommand && (i_value >= 11'(DSHOT_CMD_MAX));

endmodule

`default_nettype wire

// File: rtl/dshot_output.sv
// ============================================================================
// Module : dshot_output
// Brief  : DShot transmitter, 16-bit pulse-width-coded frame, MSB first.
//          DSHOT_BIDIR_EN selects inverted line polarity and checksum.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dshot_output
    import dshot_pkg::*;
#(
    parameter int CLK_HZ   = 16000000,
    parameter int BAUD     = 150000,
    parameter int GAP_BITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_command,
    input  logic [10:0] in_value,
    input  logic        in_telemetry,
    output logic        out_pin,
    output logic        busy,
    output logic        frame_done,
    output logic        cmd_error
);

    localparam int c_T_BIT   = CLK_HZ / BAUD;
    localparam int c_T1H     = (3 * c_T_BIT) / 4;
    localparam int c_T0H     = (3 * c_T_BIT) / 8;
    localparam int c_GAP_CYC = c_T_BIT * GAP_BITS;
    localparam int c_CNT_W   = $clog2(c_T_BIT * GAP_BITS + 1);
    localparam int c_BIT_W   = $clog2(DSHOT_FRAME_W);
`ifdef DSHOT_BIDIR_EN
    localparam logic c_IDLE_LEVEL = 1'b1;
`else
    localparam logic c_IDLE_LEVEL = 1'b0;
`endif

    dshotState_t              r_state;
    dshotState_t              w_stateNext;
    logic [c_BIT_W-1:0]       r_bitCnt;
    logic [c_BIT_W-1:0]       w_bitCntNext;
    logic [c_CNT_W-1:0]       r_cycCnt;
    logic [c_CNT_W-1:0]       w_cycCntNext;
    logic [c_CNT_W-1:0]       w_highLen;
    logic [DSHOT_FRAME_W-1:0] r_frame;
    logic [DSHOT_FRAME_W-1:0] w_frameNext;
    logic [DSHOT_FRAME_W-1:0] w_encFrame;
    logic                     w_encErr;
    logic                     w_accept;
    logic                     w_start;
    logic                     w_cycLast;
    logic                     w_gapLast;
    logic                     w_pulseOn;
    logic                     r_outPin;
    logic                     r_cmdErr;

    dshot_frame_encoder u_encoder (
        .i_isCommand (in_is_command),
        .i_value     (in_value),
        .i_telemetry (in_telemetry),
        .o_frame     (w_encFrame),
        .o_cmdErr    (w_encErr)
    );

    assign w_accept  = in_valid && in_ready;
    assign w_start   = w_accept && !w_encErr;
    assign w_cycLast = (r_cycCnt == c_CNT_W'(c_T_BIT - 1));
    // The idle cycle carrying the next handshake completes the gap, so GAP
    // itself ends one cycle early to keep back-to-back frames on a fixed pitch.
    assign w_gapLast = (r_cycCnt == c_CNT_W'(c_GAP_CYC - 2));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_stateNext;
    end

    // Next-state logic
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_stateNext = ST_SEND;
            ST_SEND: if (w_cycLast && (r_bitCnt == '0)) w_stateNext = ST_GAP;
            ST_GAP:  if (w_gapLast) w_stateNext = ST_IDLE;
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready   = (r_state == ST_IDLE);
        busy       = (r_state != ST_IDLE);
        frame_done = (r_state == ST_GAP) && (r_cycCnt == '0);
    end

    always_comb begin
        w_bitCntNext = r_bitCnt;
        w_cycCntNext = r_cycCnt;
        w_frameNext  = r_frame;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_frameNext  = w_encFrame;
                    w_bitCntNext = c_BIT_W'(DSHOT_FRAME_W - 1);
                    w_cycCntNext = '0;
                end
            end
            ST_SEND: begin
                if (w_cycLast) begin
                    w_cycCntNext = '0;
                    if (r_bitCnt != '0)
                        w_bitCntNext = r_bitCnt - 1'b1;
                end else begin
                    w_cycCntNext = r_cycCnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (w_gapLast)
                    w_cycCntNext = '0;
                else
                    w_cycCntNext = r_cycCnt + 1'b1;
            end
            default: begin
                w_bitCntNext = '0;
                w_cycCntNext = '0;
            end
        endcase
    end

    // Line level is computed from next-cycle counters so the pin is a flop.
    assign w_highLen = w_frameNext[w_bitCntNext] ? c_CNT_W'(c_T1H) : c_CNT_W'(c_T0H);
    assign w_pulseOn = (w_stateNext == ST_SEND) && (w_cycCntNext < w_highLen);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitCnt <= '0;
            r_cycCnt <= '0;
            r_frame  <= '0;
            r_outPin <= c_IDLE_LEVEL;
            r_cmdErr <= 1'b0;
        end else begin
            r_bitCnt <= w_bitCntNext;
            r_cycCnt <= w_cycCntNext;
            r_frame  <= w_frameNext;
            r_outPin <= w_pulseOn ? ~c_IDLE_LEVEL : c_IDLE_LEVEL;
            r_cmdErr <= w_accept && w_encErr;
        end
    end

    assign out_pin   = r_outPin;
    assign cmd_error = r_cmdErr;

endmodule

`default_nettype wire

// File: tb/tb_dshot_output.sv
// ============================================================================
// Module : tb_dshot_output
// Brief  : Randomised and directed bench for dshot_output with a per-cycle
//          waveform model built from frame arithmetic.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dshot_output;

    localparam int CLK_HZ   = 16000000;
    localparam int BAUD     = 150000;
    localparam int GAP_BITS = 2;
    localparam int T_BIT    = CLK_HZ / BAUD;
    localparam int T1H      = (3 * T_BIT) / 4;
    localparam int T0H      = (3 * T_BIT) / 8;
`ifdef DSHOT_BIDIR_EN
    localparam bit BIDIR = 1'b1;
`else
    localparam bit BIDIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_is_command = 1'b0;
    logic [10:0] in_value = '0;
    logic        in_telemetry = 1'b0;
    logic        in_ready;
    logic        out_pin;
    logic        busy;
    logic        frame_done;
    logic        cmd_error;

    dshot_output #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .GAP_BITS(GAP_BITS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_is_command (in_is_command),
        .in_value      (in_value),
        .in_telemetry  (in_telemetry),
        .out_pin       (out_pin),
        .busy          (busy),
        .frame_done    (frame_done),
        .cmd_error     (cmd_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit pin;
        bit busy;
        bit done;
        bit ready;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   expErr = 1'b0;

    function automatic int modelFrame(bit isCmd, int v, bit tel);
        int code, d, crc;
        code = isCmd ? v : ((v > 1999) ? 1999 : v) + 48;
        d    = code * 2 + int'(tel);
        crc  = (d ^ (d >> 4) ^ (d >> 8)) & 15;
        if (BIDIR) crc = crc ^ 15;
        return d * 16 + crc;
    endfunction

    function automatic exp_t idleExp();
        exp_t e;
        e.pin = BIDIR; e.busy = 1'b0; e.done = 1'b0; e.ready = 1'b1;
        return e;
    endfunction

    // Expected line for every cycle from the one after the handshake to the
    // last busy cycle; an empty queue means the transmitter is idle.
    task automatic planFrame(int f);
        exp_t e;
        for (int b = 15; b >= 0; b--) begin
            for (int c = 0; c < T_BIT; c++) begin
                e.ready = 1'b0; e.busy = 1'b1; e.done = 1'b0;
                e.pin = (c < (((f >> b) & 1) != 0 ? T1H : T0H)) ? !BIDIR : BIDIR;
                q.push_back(e);
            end
        end
        for (int c = 0; c < GAP_BITS * T_BIT - 1; c++) begin
            e.ready = 1'b0; e.busy = 1'b1; e.pin = BIDIR; e.done = (c == 0);
            q.push_back(e);
        end
    endtask

    initial cur = idleExp();

    always @(posedge clk) begin
        bit acc;
        bit rej;
        cyc++;
        if (!rst_n) begin
            q.delete();
            cur = idleExp();
            expErr = 1'b0;
        end else begin
            acc = cur.ready && in_valid;
            rej = in_is_command && (in_value >= 11'd48);
            expErr = acc && rej;
            if (acc && !rej)
                planFrame(modelFrame(in_is_command, int'(in_value), in_telemetry));
            if (q.size() > 0) cur = q.pop_front();
            else cur = idleExp();
        end
    end

    task automatic chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chkInt(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        e = rst_n ? cur : idleExp();
        chk("in_ready",   in_ready,   e.ready);
        chk("out_pin",    out_pin,    e.pin);
        chk("busy",       busy,       e.busy);
        chk("frame_done", frame_done, e.done);
        chk("cmd_error",  cmd_error,  rst_n ? expErr : 1'b0);
    end

    // Entered and left at a falling edge; in_valid stays high on return.
    task automatic send(bit isCmd, int v, bit tel, output int hsCyc);
        int waitN;
        waitN = 0;
        in_is_command = isCmd;
        in_value      = 11'(v);
        in_telemetry  = tel;
        in_valid      = 1'b1;
        while (!in_ready && waitN < 4000) begin
            @(negedge clk);
            waitN++;
        end
        chk("handshake_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        hsCyc = cyc;
    endtask

    task automatic idleFor(int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            in_is_command = 1'($urandom);
            in_value      = 11'($urandom);
            in_telemetry  = 1'($urandom);
        end
    endtask

    initial begin
        int h1, h2, doneCyc, n;
        bit isCmd;
        int v;

        chkInt("model_throttle0", modelFrame(0, 0, 0), BIDIR ? 'h0609 : 'h0606);
        chkInt("model_throttle1999", modelFrame(0, 1999, 1), BIDIR ? 'hFFF0 : 'hFFFF);
        chkInt("model_sat2047", modelFrame(0, 2047, 1), BIDIR ? 'hFFF0 : 'hFFFF);
        chkInt("model_cmd5", modelFrame(1, 5, 0), BIDIR ? 'h00A5 : 'h00AA);

        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_pin", out_pin, BIDIR);
        rst_n = 1'b1;
        idleFor(4);

        send(0, 0, 0, h1);
        idleFor(20);

        send(0, 1999, 1, h1);
        in_valid = 1'b0;
        doneCyc = -1;
        n = 0;
        while (doneCyc < 0 && n < 3000) begin
            @(negedge clk);
            if (frame_done) doneCyc = cyc;
            n++;
        end
        chkInt("frame_done_latency", doneCyc - h1, 16 * 106);

        send(0, 2047, 1, h1);
        send(1, 5, 0, h1);
        send(1, 50, 0, h1);
        in_valid = 1'b0;
        chk("cmd50_error", cmd_error, 1'b1);
        chk("cmd50_line_idle", out_pin, BIDIR);
        chk("cmd50_not_busy", busy, 1'b0);
        idleFor(3);

        send(0, 100, 0, h1);
        send(0, 1234, 1, h2);
        in_valid = 1'b0;
        chkInt("back_to_back_pitch", h2 - h1, (16 + 2) * 106);

        send(0, 1999, 1, h1);
        in_valid = 1'b0;
        repeat ((15 - 7) * T_BIT + 10) @(negedge clk);
        chk("bit7_active", out_pin, !BIDIR);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_pin", out_pin, BIDIR);
        chk("async_reset_ready", in_ready, 1'b1);
        chk("async_reset_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idleFor(2);
        send(0, 0, 0, h1);

        for (int i = 0; i < 12; i++) begin
            idleFor($urandom_range(0, 200));
            isCmd = ($urandom_range(0, 3) == 0);
            v = isCmd ? $urandom_range(0, 60) : $urandom_range(0, 2047);
            send(isCmd, v, 1'($urandom), h1);
            if ($urandom_range(0, 1) == 0) in_valid = 1'b0;
        end
        idleFor(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
